// File: rtl/gpu_display_pkg.sv
// Shared types and constants for the seven-segment display back-end.
package gpu_display_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;

  // Active-low segment patterns (gfedcba)
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational nibble to active-low seven-segment decoder (bit order gfedcba).
module seg7_encoder
  import gpu_display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] segments_c
);

  // Glyph lookup for 0-9, A, b, C, d, E, F
  always_comb begin
    segments_c = SEG_BLANK;
    case (nibble)
      4'h0: segments_c = 7'h40;
      4'h1: segments_c = 7'h79;
      4'h2: segments_c = 7'h24;
      4'h3: segments_c = 7'h30;
      4'h4: segments_c = 7'h19;
      4'h5: segments_c = 7'h12;
      4'h6: segments_c = 7'h02;
      4'h7: segments_c = 7'h78;
      4'h8: segments_c = 7'h00;
      4'h9: segments_c = 7'h10;
      4'hA: segments_c = 7'h08;
      4'hB: segments_c = 7'h03;
      4'hC: segments_c = 7'h46;
      4'hD: segments_c = 7'h21;
      4'hE: segments_c = 7'h06;
      4'hF: segments_c = 7'h0E;
      default: segments_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Four-digit seven-segment display controller: accepts a value over valid/ready,
// renders it as hex or as unsigned decimal (sequential double-dabble), and
// updates the registered active-low segment outputs atomically.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits (d0 always shown).
module hex_display_ctrl
  import gpu_display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BCD_DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_mode,
  output logic                        done,
  output logic [NUM_DIGITS*SEG_W-1:0] hex
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned DD_W  = BCD_W + DATA_WIDTH;

  state_t                state_q, state_d;
  logic                  accept_c;
  logic                  shift_c;
  logic                  load_c;

  logic [DATA_WIDTH-1:0] shift_q;
  logic [BCD_W-1:0]      bcd_q;
  logic [BCD_W-1:0]      bcd_adj_c;
  logic [DD_W-1:0]       dd_next_c;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mode_q;

  logic [15:0]           value16_c;
  logic [3:0]            nib_c   [NUM_DIGITS];
  logic [SEG_W-1:0]      seg_c   [NUM_DIGITS];
  logic [SEG_W-1:0]      disp_c  [NUM_DIGITS];
  logic                  overflow_c;
  logic [NUM_DIGITS*SEG_W-1:0] hex_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    shift_c  = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_d  = in_mode ? CONV : LOAD;
        end
      end
      CONV: begin
        shift_c = 1'b1;
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = LOAD;
      end
      LOAD: begin
        load_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble step: add 3 to every BCD digit >= 5, then shift {bcd, shift} left
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    dd_next_c = {bcd_adj_c, shift_q} << 1;
  end

  // Capture and conversion datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else if (accept_c) begin
      shift_q <= in_data;
      bcd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= in_mode;
    end else if (shift_c) begin
      bcd_q   <= dd_next_c[DD_W-1:DATA_WIDTH];
      shift_q <= dd_next_c[DATA_WIDTH-1:0];
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Digit source: raw nibbles in hex mode, BCD digits in decimal mode
  always_comb begin
    value16_c  = 16'(shift_q);
    overflow_c = mode_q && (bcd_q[BCD_W-1:4*NUM_DIGITS] != '0);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      nib_c[i] = mode_q ? bcd_q[4*i +: 4] : value16_c[4*i +: 4];
    end
  end

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_enc
    seg7_encoder u_enc (
      .nibble     (nib_c[g]),
      .segments_c (seg_c[g])
    );
  end

  // Final glyph selection: overflow dashes, optional leading-zero blanking
  always_comb begin
    logic lead;
    lead = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) disp_c[i] = seg_c[i];
`ifdef LEAD_ZERO_BLANK_EN
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (lead && (nib_c[i] == 4'd0)) disp_c[i] = SEG_BLANK;
      else                            lead      = 1'b0;
    end
`endif
    if (overflow_c) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) disp_c[i] = SEG_DASH;
    end
    hex_c = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) hex_c[SEG_W*i +: SEG_W] = disp_c[i];
  end

  // Registered handshake and display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      done     <= 1'b0;
      hex      <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      done <= load_c;
      if (accept_c)    in_ready <= 1'b0;
      else if (load_c) in_ready <= 1'b1;
      if (load_c)      hex      <= hex_c;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: directed scenarios plus randomized
// requests checked against an arithmetic reference model.
module tb_hex_display_ctrl;

  localparam int unsigned DW = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [DW-1:0] in_data;
  logic        in_mode;
  logic        done;
  logic [27:0] hex;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_ctrl #(.DATA_WIDTH(DW), .BCD_DIGITS(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .done     (done),
    .hex      (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display for a value, computed from digit arithmetic
  function automatic logic [27:0] model(input int v, input logic mode);
    int dig [4];
    int div;
    logic [27:0] r;
    logic [6:0] s [4];
    if (mode && v > 9999) return {4{7'h3F}};
    div = 1;
    for (int i = 0; i < 4; i++) begin
      dig[i] = mode ? (v / div) % 10 : (v >> (4 * i)) & 15;
      div = div * 10;
    end
    for (int i = 0; i < 4; i++) s[i] = seg_tab[dig[i]];
`ifdef LEAD_ZERO_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (dig[i] != 0) break;
      s[i] = 7'h7F;
    end
`endif
    r = {s[3], s[2], s[1], s[0]};
    return r;
  endfunction

  // One full request: accept, wait for done, check latency, stability and result
  task automatic request(input logic [15:0] data, input logic mode,
                         input logic [27:0] exp, input string name);
    logic [27:0] prev;
    int n;
    logic got;
    logic changed;
    int exp_lat;
    prev = hex;
    exp_lat = mode ? DW + 1 : 1;
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~data;
    in_mode  = ~mode;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL %s ready_after_accept got=%b exp=0", name, in_ready);
    else n_pass++;
    n = 0; got = 1'b0; changed = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) got = 1'b1;
      else if (hex !== prev) changed = 1'b1;
    end
    n_total++;
    if (!got || n != exp_lat) $display("FAIL %s latency got=%0d exp=%0d", name, n, exp_lat);
    else n_pass++;
    n_total++;
    if (changed) $display("FAIL %s hex_held got=changed exp=held", name);
    else n_pass++;
    n_total++;
    if (hex !== exp) $display("FAIL %s hex got=%h exp=%h", name, hex, exp);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL %s ready_at_done got=%b exp=1", name, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0) $display("FAIL %s done_one_cycle got=%b exp=0", name, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    #12;
    n_total++;
    if (hex !== 28'hFFFFFFF || in_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL reset_asserted got=%h/%b/%b exp=fffffff/1/0", hex, in_ready, done);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_total++;
    if (hex !== 28'hFFFFFFF || in_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL reset_idle got=%h/%b/%b exp=fffffff/1/0", hex, in_ready, done);
    else n_pass++;
  endtask

  task automatic test_hex_mode();
    request(16'h1A2F, 1'b0, {7'h79, 7'h08, 7'h24, 7'h0E}, "hex_1a2f");
`ifdef LEAD_ZERO_BLANK_EN
    request(16'h00A0, 1'b0, {7'h7F, 7'h7F, 7'h08, 7'h40}, "hex_00a0");
`else
    request(16'h00A0, 1'b0, {7'h40, 7'h40, 7'h08, 7'h40}, "hex_00a0");
`endif
  endtask

  task automatic test_decimal_mode();
    request(16'd1234, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}, "dec_1234");
    request(16'd9999, 1'b1, {7'h10, 7'h10, 7'h10, 7'h10}, "dec_9999");
    request(16'd10000, 1'b1, {4{7'h3F}}, "dec_10000");
    request(16'hFFFF, 1'b1, {4{7'h3F}}, "dec_ffff");
`ifdef LEAD_ZERO_BLANK_EN
    request(16'd0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "dec_0");
`else
    request(16'd0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, "dec_0");
`endif
  endtask

  // in_valid held during conversion: second value waits, accepted right after done
  task automatic test_back_to_back();
    int n;
    logic got;
    in_valid = 1'b1; in_data = 16'd1234; in_mode = 1'b1;
    @(posedge clk); #1;
    in_data = 16'd5678;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    n_total++;
    if (!got || n != DW + 1) $display("FAIL b2b_first_latency got=%0d exp=%0d", n, DW + 1);
    else n_pass++;
    n_total++;
    if (hex !== {7'h79, 7'h24, 7'h30, 7'h19}) $display("FAIL b2b_first_hex got=%h exp=%h", hex, {7'h79, 7'h24, 7'h30, 7'h19});
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL b2b_second_accept got=%b exp=0", in_ready);
    else n_pass++;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    n_total++;
    if (!got || n != DW + 1) $display("FAIL b2b_second_latency got=%0d exp=%0d", n, DW + 1);
    else n_pass++;
    n_total++;
    if (hex !== model(5678, 1'b1)) $display("FAIL b2b_second_hex got=%h exp=%h", hex, model(5678, 1'b1));
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_conv();
    logic bad;
    in_valid = 1'b1; in_data = 16'd9999; in_mode = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (hex !== 28'hFFFFFFF || in_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL midconv_reset got=%h/%b/%b exp=fffffff/1/0", hex, in_ready, done);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || in_ready !== 1'b1 || hex !== 28'hFFFFFFF) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL midconv_after_release got=activity exp=idle_blank");
    else n_pass++;
    request(16'd9999, 1'b1, {7'h10, 7'h10, 7'h10, 7'h10}, "midconv_fresh_9999");
  endtask

  task automatic test_random();
    int v;
    logic m;
    for (int k = 0; k < 40; k++) begin
      m = 1'($urandom_range(0, 1));
      if (m && $urandom_range(0, 3) != 0) v = int'($urandom_range(0, 9999));
      else                                v = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, 15));
      request(16'(v), m, model(v, m), $sformatf("rand_%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_hex_mode();
    test_decimal_mode();
    test_back_to_back();
    test_reset_mid_conv();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
